// File: rtl/fetch_buffer.sv
// fetch_buffer: two-slot line buffer between the memory arbiter and decode.
// Lines are fetched sequentially from the current fetch stream into a 128-byte
// ring. A window of up to WIN_BYTES bytes starting at dec_pc is shown to decode.
module fetch_buffer #(
  parameter int LINE_BYTES = 64,
  parameter int WIN_BYTES  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_pc,
  output logic                    mem_req,
  output logic [63:0]             mem_addr,
  input  logic                    mem_done,
  input  logic [LINE_BYTES*8-1:0] mem_line,
  output logic [WIN_BYTES*8-1:0]  dec_bytes,
  output logic [4:0]              dec_count,
  output logic [63:0]             dec_pc,
  input  logic [4:0]              dec_consume
);

  localparam int RING_BYTES = 2 * LINE_BYTES;
  localparam int PW = $clog2(RING_BYTES);   // ring pointer width
  localparam int OW = PW + 1;               // occupancy width (0..RING_BYTES)
  localparam int SW = $clog2(LINE_BYTES);   // byte offset within a line
  localparam logic [PW-1:0] LINE_STEP = PW'(LINE_BYTES);
  localparam logic [OW-1:0] LINE_OCC  = OW'(LINE_BYTES);
  localparam logic [OW-1:0] WIN_OCC   = OW'(WIN_BYTES);
  localparam logic [63:0]   LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    mem_req_r;
  logic [63:0]             mem_addr_r;
  logic [RING_BYTES*8-1:0] ring_r;
  logic [PW-1:0]           wp_r;
  logic [PW-1:0]           rp_r;
  logic [OW-1:0]           occ_r;
  logic [SW-1:0]           skip_r;
  logic [63:0]             fetch_addr_r;
  logic [63:0]             dec_pc_r;
  logic [4:0]              dec_count_r;
  logic [WIN_BYTES*8-1:0]  dec_bytes_r;

  logic [4:0]              cons_s;
  logic                    fill_s;
  logic [RING_BYTES*8-1:0] ring_next_s;
  logic [PW-1:0]           wp_next_s;
  logic [PW-1:0]           rp_next_s;
  logic [PW-1:0]           win_idx_s;
  logic [OW-1:0]           occ_next_s;
  logic [SW-1:0]           skip_next_s;
  logic [63:0]             fetch_next_s;
  logic [63:0]             pc_next_s;
  logic [4:0]              cnt_next_s;
  logic [WIN_BYTES*8-1:0]  win_next_s;

  // Clamp the consume request and write an accepted line into slot wp[MSB].
  always_comb begin
    if (dec_consume > dec_count_r) begin
      cons_s = dec_count_r;
    end else begin
      cons_s = dec_consume;
    end
    // A line arriving together with a redirect belongs to the old stream.
    fill_s = (state_r == ST_WAIT) && mem_done && !redirect_valid;
    ring_next_s = ring_r;
    if (fill_s) begin
      for (int k = 0; k < LINE_BYTES; k++) begin
        ring_next_s[{wp_r[PW-1], SW'(k), 3'b000} +: 8] = mem_line[LINE_BYTES*8-1-8*k -: 8];
      end
    end else begin
      ring_next_s = ring_r;
    end
  end

  // Next pointers, occupancy and stream addresses.
  always_comb begin
    if (redirect_valid) begin
      wp_next_s    = {PW{1'b0}};
      rp_next_s    = {{(PW-SW){1'b0}}, redirect_pc[SW-1:0]};
      occ_next_s   = {OW{1'b0}};
      skip_next_s  = redirect_pc[SW-1:0];
      fetch_next_s = redirect_pc & LINE_MASK;
      pc_next_s    = redirect_pc;
    end else begin
      rp_next_s = rp_r + PW'(cons_s);
      pc_next_s = dec_pc_r + 64'(cons_s);
      if (fill_s) begin
        wp_next_s    = wp_r + LINE_STEP;
        // Bytes ahead of the redirect offset in the first line are never valid.
        occ_next_s   = occ_r + LINE_OCC - OW'(skip_r) - OW'(cons_s);
        skip_next_s  = {SW{1'b0}};
        fetch_next_s = fetch_addr_r + 64'(LINE_BYTES);
      end else begin
        wp_next_s    = wp_r;
        occ_next_s   = occ_r - OW'(cons_s);
        skip_next_s  = skip_r;
        fetch_next_s = fetch_addr_r;
      end
    end
  end

  // Build the decode window from next-state so the outputs can be registered.
  always_comb begin
    if (occ_next_s > WIN_OCC) begin
      cnt_next_s = 5'(WIN_BYTES);
    end else begin
      cnt_next_s = occ_next_s[4:0];
    end
    win_next_s = {(WIN_BYTES*8){1'b0}};
    win_idx_s  = rp_next_s;
    for (int i = 0; i < WIN_BYTES; i++) begin
      win_idx_s = rp_next_s + PW'(i);
      if (5'(i) < cnt_next_s) begin
        win_next_s[WIN_BYTES*8-1-8*i -: 8] = ring_next_s[{win_idx_s, 3'b000} +: 8];
      end else begin
        win_next_s[WIN_BYTES*8-1-8*i -: 8] = 8'h00;
      end
    end
  end

  // Request FSM with registered request level and line address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_STOP;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 64'd0;
    end else begin
      case (state_r)
        ST_STOP: begin
          mem_req_r <= 1'b0;
          if (redirect_valid) state_r <= ST_IDLE;
          else                state_r <= ST_STOP;
        end
        ST_IDLE: begin
          if (redirect_valid) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end else if (occ_next_s <= LINE_OCC) begin
            state_r    <= ST_WAIT;
            mem_req_r  <= 1'b1;
            mem_addr_r <= fetch_addr_r;
          end else begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            mem_req_r <= 1'b0;
            // A line returning in the redirect cycle retires the old request.
            if (mem_done) state_r <= ST_IDLE;
            else          state_r <= ST_DRAIN;
          end else if (mem_done) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            mem_req_r <= 1'b1;
            state_r   <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          // Redirects here only retarget the stream; wait out the stale line.
          mem_req_r <= 1'b0;
          if (mem_done) state_r <= ST_IDLE;
          else          state_r <= ST_DRAIN;
        end
        default: begin
          state_r   <= ST_STOP;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Ring pointers, stream state and registered decode window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_r         <= {PW{1'b0}};
      rp_r         <= {PW{1'b0}};
      occ_r        <= {OW{1'b0}};
      skip_r       <= {SW{1'b0}};
      fetch_addr_r <= 64'd0;
      dec_pc_r     <= 64'd0;
      dec_count_r  <= 5'd0;
      dec_bytes_r  <= {(WIN_BYTES*8){1'b0}};
    end else begin
      wp_r         <= wp_next_s;
      rp_r         <= rp_next_s;
      occ_r        <= occ_next_s;
      skip_r       <= skip_next_s;
      fetch_addr_r <= fetch_next_s;
      dec_pc_r     <= pc_next_s;
      dec_count_r  <= cnt_next_s;
      dec_bytes_r  <= win_next_s;
    end
  end

  // Ring storage holds data only; validity is tracked by occ/rp.
  always_ff @(posedge clk) begin
    ring_r <= ring_next_s;
  end

  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign dec_bytes = dec_bytes_r;
  assign dec_count = dec_count_r;
  assign dec_pc    = dec_pc_r;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scenarios followed by randomized traffic, checked
// against an address-level model: the bytes decode sees are a pure function of
// their address, valid up to the end of the last accepted line.
module tb_fetch_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_done;
  logic [511:0] mem_line;
  logic [127:0] dec_bytes;
  logic [4:0]   dec_count;
  logic [63:0]  dec_pc;
  logic [4:0]   dec_consume;

  fetch_buffer #(.LINE_BYTES(64), .WIN_BYTES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_done       (mem_done),
    .mem_line       (mem_line),
    .dec_bytes      (dec_bytes),
    .dec_count      (dec_count),
    .dec_pc         (dec_pc),
    .dec_consume    (dec_consume)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: next byte for decode, and end of fetched bytes.
  logic [63:0] m_pc;
  logic [63:0] m_end;
  // Memory side: one outstanding request.
  bit          out_v;
  bit          out_stale;
  bit          auto_mem;
  logic [63:0] out_addr;
  int          out_lat;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [511:0] line_of(input logic [63:0] base);
    logic [511:0] l;
    l = 512'd0;
    for (int k = 0; k < 64; k++) l[511-8*k -: 8] = mem_byte(base + 64'(k));
    return l;
  endfunction

  function automatic logic [63:0] avail();
    return m_end - m_pc;
  endfunction

  function automatic logic [4:0] exp_count();
    logic [63:0] a;
    a = m_end - m_pc;
    return (a > 64'd16) ? 5'd16 : a[4:0];
  endfunction

  function automatic logic [127:0] exp_window();
    logic [127:0] w;
    int n;
    w = 128'd0;
    n = int'(exp_count());
    for (int i = 0; i < 16; i++) begin
      if (i < n) w[127-8*i -: 8] = mem_byte(m_pc + 64'(i));
    end
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then check at the falling edge.
  task automatic tick(input bit rv, input logic [63:0] rpc, input logic [4:0] cons, input bit want_done);
    bit d;
    logic [63:0] vis;
    logic [63:0] c;
    d = 1'b0;
    if (out_v) begin
      if (auto_mem) begin
        if (out_lat == 0) d = 1'b1;
        else out_lat--;
      end else begin
        d = want_done;
      end
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_consume    = cons;
    mem_done       = d;
    if (d) mem_line = line_of(out_addr);
    else for (int j = 0; j < 16; j++) mem_line[32*j +: 32] = $urandom;

    vis = (avail() > 64'd16) ? 64'd16 : avail();
    if (rv) begin
      if (out_v) out_stale = 1'b1;
      m_pc  = rpc;
      m_end = rpc;
    end else begin
      c = (64'(cons) > vis) ? vis : 64'(cons);
      if (d && !out_stale) m_end = out_addr + 64'd64;
      m_pc = m_pc + c;
    end
    if (d) out_v = 1'b0;

    @(negedge clk);
    check_eq("dec_count", 128'(dec_count), 128'(exp_count()));
    check_eq("dec_pc", 128'(dec_pc), 128'(m_pc));
    check_eq("dec_bytes", dec_bytes, exp_window());
    if (out_v && out_stale) begin
      check_eq("drain_req", 128'(mem_req), 128'(0));
    end else if (out_v) begin
      check_eq("wait_req", 128'(mem_req), 128'(1));
      check_eq("wait_addr", 128'(mem_addr), 128'({m_end[63:6], 6'd0}));
    end else if (mem_req) begin
      out_v     = 1'b1;
      out_stale = 1'b0;
      out_addr  = mem_addr;
      out_lat   = $urandom_range(0, 4);
      check_eq("req_addr", 128'(mem_addr), 128'({m_end[63:6], 6'd0}));
    end
  endtask

  initial begin
    logic [7:0] first_byte;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    mem_done = 1'b0;
    mem_line = 512'd0;
    dec_consume = 5'd0;
    m_pc = 64'd0;
    m_end = 64'd0;
    out_v = 1'b0;
    out_stale = 1'b0;
    auto_mem = 1'b0;
    out_addr = 64'd0;
    out_lat = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_req", 128'(mem_req), 128'(0));
    check_eq("rst_addr", 128'(mem_addr), 128'(0));
    check_eq("rst_count", 128'(dec_count), 128'(0));
    check_eq("rst_pc", 128'(dec_pc), 128'(0));
    check_eq("rst_bytes", dec_bytes, 128'd0);
    reset = 1'b0;

    // Stopped: no requests until the first redirect.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 64'd0, 5'd3, 1'b0);
      check_eq("stop_req", 128'(mem_req), 128'(0));
    end

    // Aligned start: full window of line bytes 0x00..0x0F.
    tick(1'b1, 64'h1000, 5'd0, 1'b0);
    check_eq("idle_req", 128'(mem_req), 128'(0));
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    check_eq("t1_req", 128'(mem_req), 128'(1));
    check_eq("t1_addr", 128'(mem_addr), 128'(64'h1000));
    tick(1'b0, 64'd0, 5'd0, 1'b1);
    check_eq("t1_count", 128'(dec_count), 128'(16));
    check_eq("t1_bytes", dec_bytes, 128'h000102030405060708090A0B0C0D0E0F);
    check_eq("t1_pc", 128'(dec_pc), 128'(64'h1000));

    // Unaligned start: only the tail of the first line is valid.
    tick(1'b1, 64'h203A, 5'd0, 1'b0);
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    check_eq("t2_addr", 128'(mem_addr), 128'(64'h2000));
    tick(1'b0, 64'd0, 5'd0, 1'b1);
    first_byte = dec_bytes[127:120];
    check_eq("t2_count", 128'(dec_count), 128'(6));
    check_eq("t2_first", 128'(first_byte), 128'(8'h3A));
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    check_eq("t2_next_req", 128'(mem_req), 128'(1));
    check_eq("t2_next_addr", 128'(mem_addr), 128'(64'h2040));

    // Redirect while waiting: the returning line is dropped.
    tick(1'b1, 64'h3010, 5'd0, 1'b0);
    check_eq("t3_drain_req", 128'(mem_req), 128'(0));
    tick(1'b0, 64'd0, 5'd0, 1'b1);
    check_eq("t3_count", 128'(dec_count), 128'(0));
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    check_eq("t3_req", 128'(mem_req), 128'(1));
    check_eq("t3_addr", 128'(mem_addr), 128'(64'h3000));

    // Redirect coinciding with the line, then an over-sized consume.
    tick(1'b1, 64'h4005, 5'd0, 1'b1);
    check_eq("t4_count0", 128'(dec_count), 128'(0));
    check_eq("t4_req0", 128'(mem_req), 128'(0));
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    check_eq("t4_addr", 128'(mem_addr), 128'(64'h4000));
    tick(1'b0, 64'd0, 5'd0, 1'b1);
    tick(1'b0, 64'd0, 5'd20, 1'b0);
    check_eq("t4_clamp_pc", 128'(dec_pc), 128'(64'h4015));
    check_eq("t4_clamp_count", 128'(dec_count), 128'(16));
    tick(1'b0, 64'd0, 5'd0, 1'b1);

    // Fill the ring completely, then free one line's worth.
    tick(1'b1, 64'h5000, 5'd0, 1'b0);
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    tick(1'b0, 64'd0, 5'd0, 1'b1);
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    check_eq("t5_addr2", 128'(mem_addr), 128'(64'h5040));
    tick(1'b0, 64'd0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 64'd0, 5'd0, 1'b0);
      check_eq("full_hold", 128'(mem_req), 128'(0));
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 64'd0, 5'd16, 1'b0);
      check_eq("full_release", 128'(mem_req), 128'(i == 3));
    end
    tick(1'b0, 64'd0, 5'd16, 1'b1);

    // Randomized traffic with variable memory latency.
    auto_mem = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      bit          r_rv;
      logic [63:0] r_pc;
      logic [4:0]  r_cons;
      r_rv = ($urandom_range(0, 99) < 2);
      r_pc = {32'd0, $urandom};
      if ((n % 300) < 60) r_cons = 5'd0;
      else r_cons = 5'($urandom_range(0, 20));
      tick(r_rv, r_pc, r_cons, 1'b0);
    end

    // Reset while a request is outstanding; its late line must be ignored.
    auto_mem = 1'b0;
    if (out_v) tick(1'b0, 64'd0, 5'd0, 1'b1);
    tick(1'b1, 64'h7000, 5'd0, 1'b0);
    tick(1'b0, 64'd0, 5'd0, 1'b0);
    check_eq("t6_req", 128'(mem_req), 128'(1));
    reset = 1'b1;
    #1;
    check_eq("async_req", 128'(mem_req), 128'(0));
    check_eq("async_addr", 128'(mem_addr), 128'(0));
    check_eq("async_count", 128'(dec_count), 128'(0));
    check_eq("async_pc", 128'(dec_pc), 128'(0));
    check_eq("async_bytes", dec_bytes, 128'd0);
    m_pc = 64'd0;
    m_end = 64'd0;
    if (out_v) out_stale = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, 64'd0, 5'd0, 1'b1);
    check_eq("stop_late_count", 128'(dec_count), 128'(0));
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 64'd0, 5'd0, 1'b0);
      check_eq("stop_late_req", 128'(mem_req), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
